rf_wb_arbiter: RTL



---
 rtl/rf_wb_arbiter_if.sv | 32 +++
 rtl/rf_wb_arbiter.sv | 122 ++++++++++++
 2 files changed

// File: rtl/rf_wb_arbiter_if.sv
// Writeback request and register-file write-port bundle.
// The master side drives requests; the slave side is the arbiter.
interface rf_wb_arbiter_if;
    logic        req0_valid;
    logic        req0_ready;
    logic [4:0]  req0_addr;
    logic [31:0] req0_data;
    logic        req1_valid;
    logic        req1_ready;
    logic [4:0]  req1_addr;
    logic [31:0] req1_data;
    logic        Reg_Write;
    logic [4:0]  W_addr;
    logic [31:0] data_write;
    logic [31:0] pending_mask;

    modport master (
        output req0_valid, req0_addr, req0_data,
        output req1_valid, req1_addr, req1_data,
        input  req0_ready, req1_ready,
        input  Reg_Write, W_addr, data_write,
        input  pending_mask
    );

    modport slave (
        input  req0_valid, req0_addr, req0_data,
        input  req1_valid, req1_addr, req1_data,
        output req0_ready, req1_ready,
        output Reg_Write, W_addr, data_write,
        output pending_mask
    );
endinterface

// File: rtl/rf_wb_arbiter.sv
// Two-requester writeback arbiter for the register-file write port.
// Optional pending-write scoreboard: define RF_WB_SCOREBOARD_EN.
module rf_wb_arbiter #(
    parameter int ARB_MODE  = 0,
    parameter int ZERO_DROP = 1
) (
    input logic            clk_W,
    input logic            rst_,
    rf_wb_arbiter_if.slave bus
);
    logic        h0_v, h1_v;
    logic [4:0]  h0_a, h1_a;
    logic [31:0] h0_d, h1_d;
    logic        age_q;
    logic        rr_q;
    logic        wr_q;
    logic [4:0]  wa_q;
    logic [31:0] wd_q;

    logic g0, g1, contest;
    logic rdy0, rdy1;
    logic drop0, drop1;
    logic st0, st1;
    logic kp0, kp1;

    // age_q=1 means hold1 is older; rr_q=1 means req1 wins next contest
    always_comb begin
        g0      = 1'b0;
        g1      = 1'b0;
        contest = 1'b0;
        case ({h0_v, h1_v})
            2'b10: g0 = 1'b1;
            2'b01: g1 = 1'b1;
            2'b11: begin
                if (h0_a == h1_a) begin
                    g0 = ~age_q;
                    g1 = age_q;
                end else begin
                    contest = 1'b1;
                    if (ARB_MODE != 0) begin
                        g1 = 1'b1;
                    end else begin
                        g0 = ~rr_q;
                        g1 = rr_q;
                    end
                end
            end
            default: ;
        endcase
    end

    assign rdy0  = ~h0_v | g0;
    assign rdy1  = ~h1_v | g1;
    assign drop0 = (ZERO_DROP != 0) && (bus.req0_addr == 5'd0);
    assign drop1 = (ZERO_DROP != 0) && (bus.req1_addr == 5'd0);
    assign st0   = bus.req0_valid & rdy0 & ~drop0;
    assign st1   = bus.req1_valid & rdy1 & ~drop1;
    assign kp0   = h0_v & ~g0;
    assign kp1   = h1_v & ~g1;

    assign bus.req0_ready = rdy0;
    assign bus.req1_ready = rdy1;
    assign bus.Reg_Write  = wr_q;
    assign bus.W_addr     = wa_q;
    assign bus.data_write = wd_q;

    always_ff @(posedge clk_W or negedge rst_) begin
        if (!rst_) begin
            h0_v  <= 1'b0;
            h0_a  <= 5'd0;
            h0_d  <= 32'd0;
            h1_v  <= 1'b0;
            h1_a  <= 5'd0;
            h1_d  <= 32'd0;
            age_q <= 1'b0;
            rr_q  <= 1'b0;
            wr_q  <= 1'b0;
            wa_q  <= 5'd0;
            wd_q  <= 32'd0;
        end else begin
            if (st0) begin
                h0_v <= 1'b1;
                h0_a <= bus.req0_addr;
                h0_d <= bus.req0_data;
            end else if (g0) begin
                h0_v <= 1'b0;
            end
            if (st1) begin
                h1_v <= 1'b1;
                h1_a <= bus.req1_addr;
                h1_d <= bus.req1_data;
            end else if (g1) begin
                h1_v <= 1'b0;
            end
            // A surviving hold1 is older than anything new in hold0
            if (!(kp0 && kp1)) age_q <= kp1;
            if (contest) rr_q <= g0;
            wr_q <= g0 | g1;
            if (g0) begin
                wa_q <= h0_a;
                wd_q <= h0_d;
            end else if (g1) begin
                wa_q <= h1_a;
                wd_q <= h1_d;
            end
        end
    end

`ifdef RF_WB_SCOREBOARD_EN
    logic [31:0] pm;
    always_comb begin
        pm = 32'd0;
        if (h0_v) pm[h0_a] = 1'b1;
        if (h1_v) pm[h1_a] = 1'b1;
        if (wr_q) pm[wa_q] = 1'b1;
        pm[0] = 1'b0;
    end
    assign bus.pending_mask = pm;
`else
    assign bus.pending_mask = 32'h0000_0000;
`endif
endmodule
